// File: rtl/mem_ctrl.sv
// mem_ctrl - single-port arbiter/sequencer for the byte-wide RAM bus.
//
// Shares one byte-wide RAM port between instruction fetch (icache refill)
// and the MEM stage (loads/stores). Every access is split into per-byte
// RAM cycles. Read bytes are reassembled little-endian. Each requester
// gets a one-cycle completion pulse.
//
// Optional feature macro: MEM_CTRL_IO_STALL_EN
//   When defined, a store byte aimed at the UART addresses 0x30000 or
//   0x30004 is held back while io_full = 1. When undefined, io_full is
//   ignored.
//
// Parameters:
//   ADDR_W  - width of all address ports
//   RAM_LAT - RAM read latency; only 1 is supported
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   if_req/if_addr  - fetch request (held until inst_valid) and word address
//   inst_o          - fetched instruction
//   inst_valid      - one-cycle fetch-done pulse
//   icache_busy     - a fetch transaction owns the bus
//   mem_enable      - data request from the MEM stage
//   mem_rw          - 0 = read, 1 = write
//   mem_type        - 00 none, 01 byte, 10 half, 11 word
//   mem_addr_i      - data address
//   mem_wdata_i     - store data, low bytes used
//   mem_data        - load result, unused upper bytes zero
//   mem_data_enable - one-cycle data-done pulse
//   ram_din/ram_dout/ram_a/ram_wr - byte-wide RAM bus
//   io_full         - UART output buffer full (optional feature only)
module mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       inst_o,
    output logic              inst_valid,
    output logic              icache_busy,
    input  logic              mem_enable,
    input  logic              mem_rw,
    input  logic [1:0]        mem_type,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_data,
    output logic              mem_data_enable,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    input  logic              io_full
);

    // The byte capture timing below assumes ram_din follows ram_a by one cycle.
    generate
        if (RAM_LAT != 1) begin : g_lat_check
            $error("mem_ctrl: only RAM_LAT = 1 is supported");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, IF_RD, D_RD, D_WR, DONE} state_t;

    state_t            state, state_d;
    logic [2:0]        cnt, cnt_d;
    logic [2:0]        n, n_d;
    logic [ADDR_W-1:0] base, base_d;
    logic [31:0]       wdata, wdata_d;
    logic [31:0]       rd_buf, rd_buf_d, rd_next;

    logic [31:0]       inst_o_d, mem_data_d;
    logic [ADDR_W-1:0] ram_a_d;
    logic [7:0]        ram_dout_d;
    logic              inst_valid_d, mem_data_enable_d, icache_busy_d, ram_wr_d;

    logic              can_accept, data_req, accept_data, accept_fetch;
    logic [2:0]        req_n, cnt_inc;
    logic              rd_last;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_stall;

    // DONE behaves like IDLE for arbitration so back-to-back transactions
    // lose no cycle; data requests always win over a pending fetch.
    assign can_accept   = (state == IDLE) || (state == DONE);
    assign data_req     = mem_enable && (mem_type != 2'b00);
    assign accept_data  = can_accept && data_req;
    assign accept_fetch = can_accept && !data_req && if_req;
    assign cnt_inc      = cnt + 3'd1;
    assign rd_last      = (cnt_inc == n);

    always_comb begin
        case (mem_type)
            2'b01:   req_n = 3'd1;
            2'b10:   req_n = 3'd2;
            default: req_n = 3'd4;
        endcase
    end

    // Address of the store byte about to be issued: on the accepting edge
    // it is the incoming address, inside D_WR it is base + bytes issued.
    assign wr_addr = (state == D_WR) ? base + ADDR_W'(cnt) : mem_addr_i;

`ifdef MEM_CTRL_IO_STALL_EN
    localparam logic [ADDR_W-1:0] IO_ADDR0 = ADDR_W'(32'h0003_0000);
    localparam logic [ADDR_W-1:0] IO_ADDR1 = ADDR_W'(32'h0003_0004);
    assign wr_stall = io_full && ((wr_addr == IO_ADDR0) || (wr_addr == IO_ADDR1));
`else
    logic unused_io_full;
    assign unused_io_full = io_full;
    assign wr_stall       = 1'b0;
`endif

    // Read assembly buffer with the byte arriving this cycle merged in.
    always_comb begin
        rd_next = rd_buf;
        rd_next[{cnt[1:0], 3'b000} +: 8] = ram_din;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE: begin
                if (accept_data) begin
                    state_d = mem_rw ? D_WR : D_RD;
                end else if (accept_fetch) begin
                    state_d = IF_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            IF_RD, D_RD: begin
                if (rd_last) begin
                    state_d = DONE;
                end
            end
            D_WR: begin
                if (cnt == n) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values. In D_WR, cnt counts bytes already
    // issued, so a stalled byte simply leaves cnt where it is.
    always_comb begin
        cnt_d             = cnt;
        n_d               = n;
        base_d            = base;
        wdata_d           = wdata;
        rd_buf_d          = rd_buf;
        inst_o_d          = inst_o;
        mem_data_d        = mem_data;
        ram_a_d           = ram_a;
        ram_dout_d        = 8'h00;
        ram_wr_d          = 1'b0;
        inst_valid_d      = 1'b0;
        mem_data_enable_d = 1'b0;
        icache_busy_d     = icache_busy;
        case (state)
            IDLE, DONE: begin
                icache_busy_d = 1'b0;
                if (accept_data) begin
                    base_d   = mem_addr_i;
                    n_d      = req_n;
                    wdata_d  = mem_wdata_i;
                    cnt_d    = 3'd0;
                    rd_buf_d = 32'h0;
                    ram_a_d  = mem_addr_i;
                    if (mem_rw && !wr_stall) begin
                        ram_dout_d = mem_wdata_i[7:0];
                        ram_wr_d   = 1'b1;
                        cnt_d      = 3'd1;
                    end
                end else if (accept_fetch) begin
                    base_d        = if_addr;
                    n_d           = 3'd4;
                    cnt_d         = 3'd0;
                    rd_buf_d      = 32'h0;
                    ram_a_d       = if_addr;
                    icache_busy_d = 1'b1;
                end
            end
            IF_RD, D_RD: begin
                rd_buf_d = rd_next;
                if (rd_last) begin
                    if (state == IF_RD) begin
                        inst_o_d     = rd_next;
                        inst_valid_d = 1'b1;
                    end else begin
                        mem_data_d        = rd_next;
                        mem_data_enable_d = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_inc;
                    ram_a_d = base + ADDR_W'(cnt_inc);
                end
            end
            D_WR: begin
                if (cnt == n) begin
                    mem_data_d        = 32'h0;
                    mem_data_enable_d = 1'b1;
                end else if (!wr_stall) begin
                    ram_a_d    = wr_addr;
                    ram_dout_d = wdata[{cnt[1:0], 3'b000} +: 8];
                    ram_wr_d   = 1'b1;
                    cnt_d      = cnt_inc;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and transaction context.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= 3'd0;
            n               <= 3'd0;
            base            <= '0;
            wdata           <= 32'h0;
            rd_buf          <= 32'h0;
            inst_o          <= 32'h0;
            mem_data        <= 32'h0;
            ram_a           <= '0;
            ram_dout        <= 8'h00;
            ram_wr          <= 1'b0;
            inst_valid      <= 1'b0;
            mem_data_enable <= 1'b0;
            icache_busy     <= 1'b0;
        end else begin
            cnt             <= cnt_d;
            n               <= n_d;
            base            <= base_d;
            wdata           <= wdata_d;
            rd_buf          <= rd_buf_d;
            inst_o          <= inst_o_d;
            mem_data        <= mem_data_d;
            ram_a           <= ram_a_d;
            ram_dout        <= ram_dout_d;
            ram_wr          <= ram_wr_d;
            inst_valid      <= inst_valid_d;
            mem_data_enable <= mem_data_enable_d;
            icache_busy     <= icache_busy_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl - self-checking bench for mem_ctrl.
//
// Single data transactions come from a vector table; arbitration, a store
// waiting behind a fetch, reset mid-fetch and the IO stall (or its absence
// in the default build) are hand-written sequences. The RAM is a small
// asynchronous-read byte array indexed by the low 10 address bits; every
// ram_wr cycle is logged for checking store bytes.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] inst_o;
    logic        inst_valid;
    logic        icache_busy;
    logic        mem_enable;
    logic        mem_rw;
    logic [1:0]  mem_type;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_data;
    logic        mem_data_enable;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_full;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32), .RAM_LAT(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .inst_o          (inst_o),
        .inst_valid      (inst_valid),
        .icache_busy     (icache_busy),
        .mem_enable      (mem_enable),
        .mem_rw          (mem_rw),
        .mem_type        (mem_type),
        .mem_addr_i      (mem_addr_i),
        .mem_wdata_i     (mem_wdata_i),
        .mem_data        (mem_data),
        .mem_data_enable (mem_data_enable),
        .ram_din         (ram_din),
        .ram_dout        (ram_dout),
        .ram_a           (ram_a),
        .ram_wr          (ram_wr),
        .io_full         (io_full)
    );

    logic [7:0] ram_mem [0:1023];
    assign ram_din = ram_mem[ram_a[9:0]];

    logic [31:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];

    always @(posedge clk) begin
        if (ram_wr) begin
            wr_addr_q.push_back(ram_a);
            wr_data_q.push_back(ram_dout);
        end
    end

    typedef struct {
        logic        rw;
        logic [1:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int byteCount(input logic [1:0] t);
        case (t)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    // Presents one data request for the acceptance edge, then watches ten
    // cycles for the done pulse.
    task automatic applyStimulus(input vec_t v, output int lat, output int pulses,
                                 output logic [31:0] data);
        wr_addr_q.delete();
        wr_data_q.delete();
        mem_enable  = 1'b1;
        mem_rw      = v.rw;
        mem_type    = v.typ;
        mem_addr_i  = v.addr;
        mem_wdata_i = v.wdata;
        lat    = 0;
        pulses = 0;
        data   = 32'h0;
        tick();
        mem_enable = 1'b0;
        mem_type   = 2'b00;
        for (int c = 1; c <= 10; c++) begin
            if (mem_data_enable) begin
                pulses++;
                if (lat == 0) begin
                    lat  = c;
                    data = mem_data;
                end
            end
            tick();
        end
    endtask

    task automatic checkWrites(input string name, input logic [31:0] addr,
                               input logic [31:0] wdata, input int n);
        checkOutput($sformatf("%s wr count", name), 32'(wr_addr_q.size()), 32'(n));
        for (int b = 0; b < n && b < wr_addr_q.size(); b++) begin
            checkOutput($sformatf("%s wr addr %0d", name, b), wr_addr_q[b], addr + 32'(b));
            checkOutput($sformatf("%s wr data %0d", name, b), 32'(wr_data_q[b]),
                        32'(wdata[8*b +: 8]));
        end
    endtask

    initial begin
        int          lat, pulses, ilat, ipulse, dlat, dpulse, n;
        logic [31:0] data, idata, ddata;

        rst         = 1'b1;
        if_req      = 1'b0;
        if_addr     = 32'h0;
        mem_enable  = 1'b0;
        mem_rw      = 1'b0;
        mem_type    = 2'b00;
        mem_addr_i  = 32'h0;
        mem_wdata_i = 32'h0;
        io_full     = 1'b0;

        for (int i = 0; i < 1024; i++) ram_mem[i] = 8'(i * 7 + 3);
        ram_mem[10'h100] = 8'h11;
        ram_mem[10'h101] = 8'h22;
        ram_mem[10'h102] = 8'h33;
        ram_mem[10'h103] = 8'h44;
        ram_mem[10'h140] = 8'h8C;
        ram_mem[10'h141] = 8'h7F;
        ram_mem[10'h3FF] = 8'hAB;
        ram_mem[10'h000] = 8'hCD;
        ram_mem[10'h001] = 8'hEF;
        ram_mem[10'h002] = 8'h12;
        ram_mem[10'h3F0] = 8'h01;
        ram_mem[10'h3F1] = 8'h02;
        ram_mem[10'h3F2] = 8'h03;
        ram_mem[10'h3F3] = 8'h04;

        vecs[0] = '{1'b0, 2'b11, 32'h0000_0100, 32'h0,         32'h4433_2211, 5};
        vecs[1] = '{1'b0, 2'b01, 32'h0000_0100, 32'h0,         32'h0000_0011, 2};
        vecs[2] = '{1'b0, 2'b10, 32'h0000_0102, 32'h0,         32'h0000_4433, 3};
        vecs[3] = '{1'b0, 2'b10, 32'h0000_0140, 32'h0,         32'h0000_7F8C, 3};
        vecs[4] = '{1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0,         32'h12EF_CDAB, 5};
        vecs[5] = '{1'b1, 2'b01, 32'h0000_0200, 32'hDEAD_BEA5, 32'h0,         2};
        vecs[6] = '{1'b1, 2'b10, 32'h0000_0210, 32'h1234_BEEF, 32'h0,         3};
        vecs[7] = '{1'b1, 2'b11, 32'h0000_0220, 32'hCAFE_F00D, 32'h0,         5};
        vecs[8] = '{1'b1, 2'b00, 32'h0000_0230, 32'h5555_5555, 32'h0,         0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset inst_o",          inst_o,                  32'h0);
        checkOutput("reset inst_valid",      32'(inst_valid),         32'h0);
        checkOutput("reset icache_busy",     32'(icache_busy),        32'h0);
        checkOutput("reset mem_data",        mem_data,                32'h0);
        checkOutput("reset mem_data_enable", 32'(mem_data_enable),    32'h0);
        checkOutput("reset ram_a",           ram_a,                   32'h0);
        checkOutput("reset ram_dout",        32'(ram_dout),           32'h0);
        checkOutput("reset ram_wr",          32'(ram_wr),             32'h0);
        rst = 1'b0;
        tick();

        // Table-driven single data transactions
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], lat, pulses, data);
            checkOutput($sformatf("v%0d pulses", i), 32'(pulses),
                        (vecs[i].exp_lat != 0) ? 32'd1 : 32'd0);
            if (vecs[i].exp_lat != 0) begin
                checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
                checkOutput($sformatf("v%0d data", i), data, vecs[i].exp_data);
            end
            n = vecs[i].rw ? byteCount(vecs[i].typ) : 0;
            checkWrites($sformatf("v%0d", i), vecs[i].addr, vecs[i].wdata, n);
        end

        // Fetch and LH in the same cycle: data first, fetch taken at its DONE edge
        $display("[TB] arbitration sequence");
        if_req      = 1'b1;
        if_addr     = 32'h0000_03F0;
        mem_enable  = 1'b1;
        mem_rw      = 1'b0;
        mem_type    = 2'b10;
        mem_addr_i  = 32'h0000_0100;
        tick();
        mem_enable = 1'b0;
        mem_type   = 2'b00;
        ilat = 0; ipulse = 0; dlat = 0; dpulse = 0; idata = 32'h0; ddata = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            checkOutput($sformatf("arb busy c%0d", c), 32'(icache_busy),
                        32'((c >= 4) && (c <= 8)));
            if (mem_data_enable) begin
                dpulse++;
                dlat  = c;
                ddata = mem_data;
            end
            if (inst_valid) begin
                ipulse++;
                ilat   = c;
                idata  = inst_o;
                if_req = 1'b0;
            end
            tick();
        end
        if_req = 1'b0;
        checkOutput("arb data pulses", 32'(dpulse), 32'd1);
        checkOutput("arb data latency", 32'(dlat), 32'd3);
        checkOutput("arb data value", ddata, 32'h0000_2211);
        checkOutput("arb inst pulses", 32'(ipulse), 32'd1);
        checkOutput("arb inst latency", 32'(ilat), 32'd8);
        checkOutput("arb inst value", idata, 32'h0403_0201);

        // SW arriving during a fetch waits until the fetch completes
        $display("[TB] store behind fetch sequence");
        wr_addr_q.delete();
        wr_data_q.delete();
        if_req  = 1'b1;
        if_addr = 32'h0000_03F0;
        tick();
        ilat = 0; dlat = 0; ipulse = 0; dpulse = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 2) begin
                mem_enable  = 1'b1;
                mem_rw      = 1'b1;
                mem_type    = 2'b11;
                mem_addr_i  = 32'h0000_0300;
                mem_wdata_i = 32'h89AB_CDEF;
            end
            checkOutput($sformatf("sbf busy c%0d", c), 32'(icache_busy), 32'(c <= 5));
            checkOutput($sformatf("sbf ram_wr c%0d", c), 32'(ram_wr),
                        32'((c >= 6) && (c <= 9)));
            if (ram_wr) begin
                mem_enable = 1'b0;
                mem_type   = 2'b00;
            end
            if (inst_valid) begin
                ipulse++;
                ilat   = c;
                if_req = 1'b0;
            end
            if (mem_data_enable) begin
                dpulse++;
                dlat = c;
            end
            tick();
        end
        if_req     = 1'b0;
        mem_enable = 1'b0;
        mem_type   = 2'b00;
        checkOutput("sbf inst pulses", 32'(ipulse), 32'd1);
        checkOutput("sbf inst latency", 32'(ilat), 32'd5);
        checkOutput("sbf data pulses", 32'(dpulse), 32'd1);
        checkOutput("sbf data latency", 32'(dlat), 32'd10);
        checkWrites("sbf", 32'h0000_0300, 32'h89AB_CDEF, 4);

        // Reset in the middle of a fetch
        $display("[TB] reset mid-fetch sequence");
        if_req  = 1'b1;
        if_addr = 32'h0000_03F0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("rmf inst_o",          inst_o,               32'h0);
        checkOutput("rmf inst_valid",      32'(inst_valid),      32'h0);
        checkOutput("rmf icache_busy",     32'(icache_busy),     32'h0);
        checkOutput("rmf mem_data",        mem_data,             32'h0);
        checkOutput("rmf mem_data_enable", 32'(mem_data_enable), 32'h0);
        checkOutput("rmf ram_a",           ram_a,                32'h0);
        checkOutput("rmf ram_dout",        32'(ram_dout),        32'h0);
        checkOutput("rmf ram_wr",          32'(ram_wr),          32'h0);
        rst    = 1'b0;
        if_req = 1'b0;
        ipulse = 0;
        for (int c = 0; c < 8; c++) begin
            if (inst_valid) ipulse++;
            tick();
        end
        checkOutput("rmf no inst_valid", 32'(ipulse), 32'd0);
        applyStimulus('{1'b0, 2'b01, 32'h0000_0101, 32'h0, 32'h0, 0}, lat, pulses, data);
        checkOutput("rmf lb pulses", 32'(pulses), 32'd1);
        checkOutput("rmf lb latency", 32'(lat), 32'd2);
        checkOutput("rmf lb data", data, 32'h0000_0022);

        // Store to the UART address with io_full high for three cycles
        $display("[TB] io_full store sequence");
        wr_addr_q.delete();
        wr_data_q.delete();
        io_full     = 1'b1;
        mem_enable  = 1'b1;
        mem_rw      = 1'b1;
        mem_type    = 2'b01;
        mem_addr_i  = 32'h0003_0000;
        mem_wdata_i = 32'h0000_005A;
        tick();
        mem_enable = 1'b0;
        mem_type   = 2'b00;
        dlat = 0; dpulse = 0;
        for (int c = 1; c <= 8; c++) begin
`ifdef MEM_CTRL_IO_STALL_EN
            if (c == 3) io_full = 1'b0;
            checkOutput($sformatf("io ram_wr c%0d", c), 32'(ram_wr), 32'(c == 4));
`else
            checkOutput($sformatf("io ram_wr c%0d", c), 32'(ram_wr), 32'(c == 1));
`endif
            if (mem_data_enable) begin
                dpulse++;
                dlat = c;
            end
            tick();
        end
        io_full = 1'b0;
        checkOutput("io data pulses", 32'(dpulse), 32'd1);
`ifdef MEM_CTRL_IO_STALL_EN
        checkOutput("io data latency", 32'(dlat), 32'd5);
`else
        checkOutput("io data latency", 32'(dlat), 32'd2);
`endif
        checkWrites("io", 32'h0003_0000, 32'h0000_005A, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Single-port arbiter/sequencer for the byte-wide RAM bus, shared between instruction fetch (icache miss refill) and the MEM stage (loads/stores).
- Serialises each b/h/w access into per-byte RAM cycles and reassembles read data little-endian.
- Returns one-cycle completion pulses to each requester.
- Exports icache_busy so the MEM stage holds off while a fetch owns the bus.

Parameters:
ADDR_W, 32, width of all address ports
RAM_LAT, 1, cycles from ram_a valid to ram_din valid; only 1 supported, other values are a lint error

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset, sampled on rising edge of clk
if_req  input  1  fetch request; held until inst_valid
if_addr  input  ADDR_W  fetch address (word fetch)
inst_o  output  32  fetched instruction
inst_valid  output  1  one-cycle fetch-done pulse
icache_busy  output  1  fetch transaction owns the bus
mem_enable  input  1  data request from MEM stage
mem_rw  input  1  0 = read, 1 = write
mem_type  input  2  00 none, 01 b, 10 h, 11 w
mem_addr_i  input  ADDR_W  data address
mem_wdata_i  input  32  store data, low bytes used
mem_data  output  32  load result, unused upper bytes zero
mem_data_enable  output  1  one-cycle data-done pulse (load or store)
ram_din  input  8  RAM read byte
ram_dout  output  8  RAM write byte
ram_a  output  ADDR_W  RAM byte address
ram_wr  output  1  RAM write strobe
io_full  input  1  UART output buffer full (used only with the optional feature)

Behaviour:
- All outputs registered.
- Reset values:
  - inst_o, mem_data, ram_a, ram_dout = 0.
  - inst_valid, mem_data_enable, icache_busy, ram_wr = 0.
  - State IDLE, byte counter cnt = 0.
- Byte count n:
  - b = 1, h = 2, w = 4; fetch always 4.
  - mem_type 00 with mem_enable = 1 is ignored; stays IDLE.
- States: IDLE, IF_RD, D_RD, D_WR, DONE.
- IDLE arbitration, at the rising edge:
  - Data request (mem_enable = 1, type != 00) beats if_req.
  - Accepted transaction latches base address, n and wdata; cnt <= 0.
  - Accepting a fetch sets icache_busy.
- No preemption: a transaction in progress always runs to completion. Requests arriving meanwhile wait in IDLE.
- Read (IF_RD / D_RD):
  - Acceptance edge k=0 drives ram_a = base, ram_wr = 0.
  - At edge k (1..n): capture ram_din into byte k-1 of the assembly register; if k<n, drive ram_a = base+k.
  - At edge n: state <= DONE.
  - In DONE: result is presented on inst_o or mem_data and the matching valid is pulsed high for exactly one cycle. For data, byte 0 sits at bits 7:0 and bits above 8n are zero.
  - Latency: valid high in cycle n+1 after acceptance (LW/fetch: cycle 5, LB: cycle 2).
- Write (D_WR):
  - Edges 0..n-1 drive ram_a = base+k, ram_dout = wdata byte k, ram_wr = 1.
  - Edge n: ram_wr = 0, state <= DONE.
  - mem_data_enable pulses in cycle n+1; mem_data = 0.
- DONE always returns to IDLE on the next edge. IDLE may accept a new request in that same edge (back-to-back allowed).
- icache_busy: high from the fetch acceptance edge through the inst_valid cycle inclusive, else 0.
- Address wrap: base+k wraps modulo 2^ADDR_W. No alignment check.
- While not writing: ram_wr = 0 and ram_dout = 0.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. No done pulse, no partial write continuation.

Optional Feature:
MEM_CTRL_IO_STALL_EN:
- Defined: a D_WR byte whose address is 0x30000 or 0x30004 while io_full = 1 is not issued. ram_wr = 0 and cnt is held until io_full = 0; the byte then issues and the remaining timing shifts by the stall cycles.
- Undefined: io_full is ignored and writes never stall.

Test Plan:
- LW addr 0x100, RAM bytes 11,22,33,44 -> ram_a 0x100..0x103 on consecutive cycles; mem_data = 0x44332211; mem_data_enable high only in cycle 5.
- SB addr 0x200, wdata 0xDEADBEA5 -> one ram_wr cycle, ram_a 0x200, ram_dout 0xA5; done pulse in cycle 2; ram_wr low afterwards.
- if_req and LH read asserted in the same cycle -> data served first, icache_busy = 0 throughout; fetch accepted in the DONE edge; inst_valid 5 cycles later.
- SW to 0x300 arriving during a fetch -> waits; icache_busy = 1 until inst_valid; store bytes issued after.
- rst asserted at byte 2 of a fetch -> next cycle all outputs 0, state IDLE, no inst_valid; a subsequent LB completes normally.
- MEM_CTRL_IO_STALL_EN: SB to 0x30000 with io_full = 1 for 3 cycles -> ram_wr withheld 3 cycles, then 1 write; done pulse in cycle 5.
